error_stats_accum: RTL and testbench

ERROR_STATS_ACCUM -- requirements
Module: error_stats_accum

---
 rtl/approx_pkg.sv | 13 +
 rtl/err_dist.sv | 19 +
 rtl/error_stats_accum.sv | 121 ++++++++++++
 tb/tb_error_stats_accum.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared constants and FSM state type for the approximate-multiplier metric blocks.
package approx_pkg;

    localparam int P_W_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/err_dist.sv
// Combinational unsigned error distance |a - b|, shared by the metric blocks.
module err_dist #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
    end

endmodule

// File: rtl/error_stats_accum.sv
// Accumulates error statistics (error count, summed and maximum error distance)
// over a run of exact/approximate product pairs of a programmable length.
module error_stats_accum
    import approx_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [P_W-1:0]       s_ex,
    input  logic [P_W-1:0]       s_ap,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [P_W+CNT_W-1:0] sum_ed,
    output logic [P_W-1:0]       max_ed,
    output logic [CNT_W-1:0]     smp_cnt
);

    localparam int SUM_W = P_W + CNT_W;

    state_e             state_r,   state_nxt_s;
    logic [CNT_W-1:0]   n_lat_r,   n_lat_nxt_s;
    logic [CNT_W-1:0]   err_cnt_r, err_cnt_nxt_s;
    logic [SUM_W-1:0]   sum_ed_r,  sum_ed_nxt_s;
    logic [P_W-1:0]     max_ed_r,  max_ed_nxt_s;
    logic [CNT_W-1:0]   smp_cnt_r, smp_cnt_nxt_s;
    logic [CNT_W-1:0]   smp_inc_s;
    logic [P_W-1:0]     ed_s;
    logic               accept_s;

    err_dist #(.W(P_W)) u_err_dist (
        .a (s_ex),
        .b (s_ap),
        .d (ed_s)
    );

    assign accept_s  = s_valid && (state_r == ST_RUN);
    assign smp_inc_s = smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and next-statistics computation for the run controller.
    always_comb begin
        state_nxt_s   = state_r;
        n_lat_nxt_s   = n_lat_r;
        err_cnt_nxt_s = err_cnt_r;
        sum_ed_nxt_s  = sum_ed_r;
        max_ed_nxt_s  = max_ed_r;
        smp_cnt_nxt_s = smp_cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_cnt_nxt_s = {CNT_W{1'b0}};
                    sum_ed_nxt_s  = {SUM_W{1'b0}};
                    max_ed_nxt_s  = {P_W{1'b0}};
                    smp_cnt_nxt_s = {CNT_W{1'b0}};
                    n_lat_nxt_s   = n_samples;
                    if (n_samples == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: a run cannot be restarted.
                if (accept_s) begin
                    sum_ed_nxt_s  = sum_ed_r + {{CNT_W{1'b0}}, ed_s};
                    max_ed_nxt_s  = (ed_s > max_ed_r) ? ed_s : max_ed_r;
                    err_cnt_nxt_s = (ed_s != {P_W{1'b0}}) ?
                                    (err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) : err_cnt_r;
                    smp_cnt_nxt_s = smp_inc_s;
                    if (smp_inc_s == n_lat_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run and clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            n_lat_r   <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            sum_ed_r  <= {SUM_W{1'b0}};
            max_ed_r  <= {P_W{1'b0}};
            smp_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            n_lat_r   <= n_lat_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            sum_ed_r  <= sum_ed_nxt_s;
            max_ed_r  <= max_ed_nxt_s;
            smp_cnt_r <= smp_cnt_nxt_s;
        end
    end

    assign busy    = (state_r == ST_RUN);
    assign done    = (state_r == ST_DONE);
    assign s_ready = (state_r == ST_RUN);
    assign err_cnt = err_cnt_r;
    assign sum_ed  = sum_ed_r;
    assign max_ed  = max_ed_r;
    assign smp_cnt = smp_cnt_r;

endmodule

// File: tb/tb_error_stats_accum.sv
// Self-checking bench for error_stats_accum: directed table, corner sequences
// and randomized runs against a behavioural statistics model.
module tb_error_stats_accum;

    localparam int P_W   = 4;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [CNT_W-1:0]     n_samples;
    logic                 s_valid;
    logic                 s_ready;
    logic [P_W-1:0]       s_ex;
    logic [P_W-1:0]       s_ap;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     err_cnt;
    logic [P_W+CNT_W-1:0] sum_ed;
    logic [P_W-1:0]       max_ed;
    logic [CNT_W-1:0]     smp_cnt;

    int n_chk = 0;
    int n_err = 0;

    error_stats_accum #(.P_W(P_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_samples (n_samples),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_ex      (s_ex),
        .s_ap      (s_ap),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .smp_cnt   (smp_cnt)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        int ex;
        int ap;
        int e_err;
        int e_sum;
        int e_max;
        int e_smp;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string nm, input int e, input int s, input int m, input int c);
        chk({nm, "_err_cnt"}, int'(err_cnt), e);
        chk({nm, "_sum_ed"},  int'(sum_ed),  s);
        chk({nm, "_max_ed"},  int'(max_ed),  m);
        chk({nm, "_smp_cnt"}, int'(smp_cnt), c);
    endtask

    task automatic do_start(input int n);
        n_samples = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_samples = CNT_W'($urandom);
    endtask

    task automatic beat(input int ex, input int ap);
        s_valid = 1'b1;
        s_ex = P_W'(ex);
        s_ap = P_W'(ap);
        tick();
        s_valid = 1'b0;
        s_ex = P_W'($urandom);
        s_ap = P_W'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            s_ex = P_W'($urandom);
            s_ap = P_W'($urandom);
            tick();
        end
    endtask

    // Main stimulus and checking sequence.
    initial begin
        int m_err, m_sum, m_max, m_smp, n, ed, cyc, ex, ap;
        bit running, v;

        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
        n_samples = '0; s_ex = '0; s_ap = '0;
        tick(); tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(s_ready), 0);
        chk_stats("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        idle_cycles(3);
        chk("post_rst_idle_busy", int'(busy), 0);
        chk("post_rst_idle_done", int'(done), 0);

        // Directed run from a table of pairs with cumulative expected stats.
        tbl[0] = '{4, 4, 0, 0, 0, 1};
        tbl[1] = '{9, 7, 1, 2, 2, 2};
        tbl[2] = '{6, 6, 1, 2, 2, 3};
        tbl[3] = '{1, 3, 2, 4, 2, 4};
        do_start(4);
        chk("t_busy", int'(busy), 1);
        chk("t_ready", int'(s_ready), 1);
        for (int i = 0; i < 4; i++) begin
            beat(tbl[i].ex, tbl[i].ap);
            chk_stats($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_sum, tbl[i].e_max, tbl[i].e_smp);
            chk($sformatf("tbl%0d_done", i), int'(done), (i == 3) ? 1 : 0);
        end
        chk("t_end_busy", int'(busy), 0);

        // Zero-length run goes straight to DONE with cleared stats.
        do_start(0);
        chk("n0_done", int'(done), 1);
        chk("n0_ready", int'(s_ready), 0);
        chk_stats("n0", 0, 0, 0, 0);
        idle_cycles(1);
        chk("n0_ready2", int'(s_ready), 0);

        // Stalled run with extreme error distances.
        do_start(3);
        beat(0, 15);
        idle_cycles(5);
        chk("stall_smp", int'(smp_cnt), 1);
        chk("stall_busy", int'(busy), 1);
        beat(15, 0);
        idle_cycles(5);
        chk("stall_smp2", int'(smp_cnt), 2);
        beat(2, 2);
        chk("stall_done", int'(done), 1);
        chk_stats("stall", 2, 30, 15, 3);
        // Results must hold in DONE even with valid data presented.
        s_valid = 1'b1;
        idle_cycles(3);
        s_valid = 1'b0;
        chk_stats("hold", 2, 30, 15, 3);
        chk("hold_done", int'(done), 1);

        // start while busy is ignored and does not re-sample n_samples.
        do_start(2);
        n_samples = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", int'(busy), 1);
        beat(5, 5);
        chk("ign_smp1", int'(smp_cnt), 1);
        chk("ign_busy1", int'(busy), 1);
        beat(7, 4);
        chk("ign_done", int'(done), 1);
        chk("ign_smp2", int'(smp_cnt), 2);

        // Back-to-back: start from DONE clears stats on the same edge.
        do_start(3);
        chk_stats("b2b_clr", 0, 0, 0, 0);
        chk("b2b_busy", int'(busy), 1);
        beat(5, 2);
        chk_stats("b2b", 1, 3, 3, 1);
        beat(1, 1);
        beat(0, 1);
        chk_stats("b2b_end", 2, 4, 3, 3);
        chk("b2b_done", int'(done), 1);

        // Longest run with maximum distance on every beat.
        do_start(255);
        for (int i = 0; i < 255; i++) begin
            beat(15, 0);
        end
        chk("max_done", int'(done), 1);
        chk_stats("max", 255, 3825, 15, 255);

        // Randomized runs checked against a behavioural model.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 30);
            m_err = 0; m_sum = 0; m_max = 0; m_smp = 0;
            do_start(n);
            running = 1'b1;
            cyc = 0;
            while (running && cyc < 2000) begin
                v = ($urandom_range(0, 2) != 0);
                ex = $urandom_range(0, 15);
                ap = ($urandom_range(0, 3) == 0) ? ex : $urandom_range(0, 15);
                s_valid = v;
                s_ex = P_W'(ex);
                s_ap = P_W'(ap);
                chk("rnd_ready", int'(s_ready), 1);
                if (v) begin
                    ed = (ex > ap) ? ex - ap : ap - ex;
                    m_sum += ed;
                    if (ed > m_max) m_max = ed;
                    if (ed != 0) m_err++;
                    m_smp++;
                    if (m_smp == n) running = 1'b0;
                end
                tick();
                cyc++;
                chk_stats($sformatf("rnd%0d", r), m_err, m_sum, m_max, m_smp);
            end
            s_valid = 1'b0;
            if (running) chk("rnd_timeout", 1, 0);
            chk("rnd_done", int'(done), 1);
            chk("rnd_busy", int'(busy), 0);
        end

        // Asynchronous reset mid-run aborts and clears everything.
        do_start(5);
        beat(9, 1);
        beat(3, 12);
        chk("pre_rst_sum", int'(sum_ed), 17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ready", int'(s_ready), 0);
        chk_stats("arst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        s_valid = 1'b1;
        idle_cycles(2);
        s_valid = 1'b0;
        chk("arst_idle", int'(busy), 0);
        chk("arst_idle_smp", int'(smp_cnt), 0);
        do_start(1);
        beat(3, 1);
        chk("arst_new_done", int'(done), 1);
        chk_stats("arst_new", 1, 2, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
